// File: rtl/core_result_writer.sv
// Result writer: captures the packed per-core result bus and streams it
// out lane by lane as addressed 32-bit words over a valid/ready handshake.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start_run_i     clears address, overrun flag and any held capture
//   result_i        packed core results, lane 0 in the LSBs
//   valid_core_i    single-cycle strobe: result_i is valid
//   data_o, addr_o  current output word and its memory address
//   valid_o         data_o/addr_o valid; held until ready_i
//   ready_i         sink accepts the word when valid_o && ready_i
//   busy_o          a capture is held and not yet fully sent
//   overrun_o       sticky: a valid_core_i was dropped
module core_result_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CORES  = 4,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_run_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] result_i,
    input  logic                            valid_core_i,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic [CNT_WIDTH-1:0]            addr_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            busy_o,
    output logic                            overrun_o
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                          state;
    logic [NUM_CORES*DATA_WIDTH-1:0] cap_buf;
    logic [IDX_W-1:0]                idx;
    logic [CNT_WIDTH-1:0]            addr;

    logic [DATA_WIDTH-1:0] lanes [NUM_CORES];
    logic [IDX_W-1:0]      idx_inc;
    logic [CNT_WIDTH-1:0]  addr_inc;
    logic                  last_lane;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
        assign lanes[g] = cap_buf[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign idx_inc   = idx + 1'b1;
    // Natural wrap of the counter gives the modulo-2^CNT_WIDTH address.
    assign addr_inc  = addr + 1'b1;
    assign last_lane = (idx == LAST_IDX);

    // addr tracks the address of the word on the bus while in SEND,
    // and the next address to be used while in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_buf   <= '0;
            idx       <= '0;
            addr      <= '0;
            data_o    <= '0;
            addr_o    <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else if (start_run_i) begin
            state     <= IDLE;
            idx       <= '0;
            addr      <= '0;
            addr_o    <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_core_i) begin
                        cap_buf <= result_i;
                        idx     <= '0;
                        data_o  <= result_i[DATA_WIDTH-1:0];
                        addr_o  <= addr;
                        valid_o <= 1'b1;
                        busy_o  <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (ready_i) begin
                        addr   <= addr_inc;
                        addr_o <= addr_inc;
                        if (!last_lane) begin
                            idx    <= idx_inc;
                            data_o <= lanes[idx_inc];
                            if (valid_core_i) overrun_o <= 1'b1;
                        end else if (valid_core_i) begin
                            // Back-to-back: refill on the final accept.
                            cap_buf <= result_i;
                            idx     <= '0;
                            data_o  <= result_i[DATA_WIDTH-1:0];
                        end else begin
                            idx     <= '0;
                            valid_o <= 1'b0;
                            busy_o  <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (valid_core_i) begin
                        overrun_o <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_result_writer.sv
// Directed bench for core_result_writer: transfer, backpressure,
// back-to-back, overrun, address wrap and mid-transfer reset.
module tb_core_result_writer;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int CW = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_run_i;
    logic [NC*DW-1:0] result_i;
    logic            valid_core_i;
    logic [DW-1:0]   data_o;
    logic [CW-1:0]   addr_o;
    logic            valid_o;
    logic            ready_i;
    logic            busy_o;
    logic            overrun_o;

    int checks = 0;
    int errors = 0;

    localparam logic [NC*DW-1:0] R1 =
        {32'h4, 32'h3, 32'h2, 32'h1};
    localparam logic [NC*DW-1:0] RA =
        {32'hD, 32'hC, 32'hB, 32'hA};

    always #5 clk = ~clk;

    core_result_writer #(
        .DATA_WIDTH(DW),
        .NUM_CORES (NC),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_run_i (start_run_i),
        .result_i    (result_i),
        .valid_core_i(valid_core_i),
        .data_o      (data_o),
        .addr_o      (addr_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run();
        start_run_i = 1'b1;
        tick();
        start_run_i = 1'b0;
    endtask

    task automatic capture(input logic [NC*DW-1:0] r);
        result_i     = r;
        valid_core_i = 1'b1;
        tick();
        valid_core_i = 1'b0;
    endtask

    logic [6:0] bp_pat;
    int         acc;

    initial begin
        rst_n        = 1'b0;
        start_run_i  = 1'b0;
        result_i     = '0;
        valid_core_i = 1'b0;
        ready_i      = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_ovr", 64'(overrun_o), 64'd0);
        chk("rst_addr", 64'(addr_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        rst_n = 1'b1;
        start_run();

        // Basic transfer
        ready_i = 1'b1;
        capture(R1);
        for (int k = 0; k < NC; k++) begin
            chk("basic_valid", 64'(valid_o), 64'd1);
            chk("basic_busy", 64'(busy_o), 64'd1);
            chk("basic_data", 64'(data_o), 64'(k + 1));
            chk("basic_addr", 64'(addr_o), 64'(k));
            tick();
        end
        chk("basic_end_valid", 64'(valid_o), 64'd0);
        chk("basic_end_busy", 64'(busy_o), 64'd0);

        // Backpressure: pattern applied LSB first
        start_run();
        ready_i = 1'b0;
        capture(R1);
        bp_pat = 7'b1011001;
        acc    = 0;
        for (int i = 0; i < 7; i++) begin
            chk("bp_valid", 64'(valid_o), 64'd1);
            chk("bp_data", 64'(data_o), 64'(acc + 1));
            chk("bp_addr", 64'(addr_o), 64'(acc));
            ready_i = bp_pat[i];
            tick();
            if (bp_pat[i]) acc++;
        end
        ready_i = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd4);
        chk("bp_end_valid", 64'(valid_o), 64'd0);

        // Back-to-back capture on the last accept
        start_run();
        ready_i = 1'b1;
        capture(R1);
        for (int k = 0; k < NC; k++) begin
            chk("b2b_data1", 64'(data_o), 64'(k + 1));
            chk("b2b_addr1", 64'(addr_o), 64'(k));
            if (k == NC - 1) begin
                result_i     = RA;
                valid_core_i = 1'b1;
            end
            tick();
            valid_core_i = 1'b0;
        end
        for (int k = 0; k < NC; k++) begin
            chk("b2b_valid2", 64'(valid_o), 64'd1);
            chk("b2b_data2", 64'(data_o), 64'(32'hA + k));
            chk("b2b_addr2", 64'(addr_o), 64'(4 + k));
            tick();
        end
        chk("b2b_end_valid", 64'(valid_o), 64'd0);
        chk("b2b_ovr", 64'(overrun_o), 64'd0);

        // Overrun while lane 1 pending
        start_run();
        ready_i = 1'b0;
        capture(R1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        capture(RA);
        chk("ovr_set", 64'(overrun_o), 64'd1);
        chk("ovr_hold_data", 64'(data_o), 64'd2);
        chk("ovr_hold_addr", 64'(addr_o), 64'd1);
        ready_i = 1'b1;
        for (int k = 1; k < NC; k++) begin
            chk("ovr_data", 64'(data_o), 64'(k + 1));
            chk("ovr_addr", 64'(addr_o), 64'(k));
            tick();
        end
        chk("ovr_end_valid", 64'(valid_o), 64'd0);
        chk("ovr_sticky", 64'(overrun_o), 64'd1);
        start_run();
        chk("ovr_clr", 64'(overrun_o), 64'd0);
        chk("ovr_clr_addr", 64'(addr_o), 64'd0);

        // Address wrap over 1024 captures
        start_run();
        ready_i = 1'b1;
        for (int c = 0; c < 1024; c++) begin
            capture(R1);
            for (int k = 0; k < NC; k++) begin
                if (c == 1023 && k == NC - 1) begin
                    chk("wrap_last_addr", 64'(addr_o), 64'd4095);
                    chk("wrap_last_data", 64'(data_o), 64'd4);
                end
                tick();
            end
        end
        capture(RA);
        chk("wrap_first_addr", 64'(addr_o), 64'd0);
        chk("wrap_first_data", 64'(data_o), 64'hA);
        for (int k = 0; k < NC; k++) tick();
        chk("wrap_end_valid", 64'(valid_o), 64'd0);

        // Reset after two words accepted
        start_run();
        ready_i = 1'b1;
        capture(R1);
        tick();
        tick();
        chk("mid_pre_data", 64'(data_o), 64'd3);
        rst_n   = 1'b0;
        ready_i = 1'b0;
        tick();
        chk("mid_valid", 64'(valid_o), 64'd0);
        chk("mid_busy", 64'(busy_o), 64'd0);
        chk("mid_addr", 64'(addr_o), 64'd0);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        capture(RA);
        chk("mid_new_valid", 64'(valid_o), 64'd1);
        chk("mid_new_data", 64'(data_o), 64'hA);
        chk("mid_new_addr", 64'(addr_o), 64'd0);
        for (int k = 0; k < NC; k++) tick();
        chk("mid_end_valid", 64'(valid_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
